instr_fetch_queue: RTL and testbench

- Producer side of the instruction-decode interface.
- Generates sequential 64-bit fetch PCs and issues requests to the instruction memory port.
- Buffers in-order 32-bit responses in a small FIFO and presents {instr, pc} to the decode stage over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/instr_fetch_queue.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch, in-order response FIFO, redirect flush.
// Define FETCH_BYPASS_EN to let a response reach decode in its arrival cycle when the FIFO is empty.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [63:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [63:0] instr_pc_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [63:0]   pc_q, pc_d;
    logic [63:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [31:0]   data_mem [DEPTH];
    logic [63:0]   pc_mem [DEPTH];

    logic [CW:0]   inflight;
    logic [63:0]   redir_pc;
    logic          accept;
    logic          rsp_keep;
    logic          empty;
    logic          byp;
    logic          pop;
    logic          fifo_pop;
    logic          push;
    logic          unused_lsb;

    assign unused_lsb = ^redirect_pc_i[1:0];
    assign redir_pc   = {redirect_pc_i[63:2], 2'b00};

    // Occupancy plus in-flight never exceeds DEPTH, so a response always finds room.
    assign inflight = {1'b0, cnt_q} + {1'b0, outst_q};
    assign imem_req_valid_o = !reset && !redirect_i && (inflight < DEPTH_W);
    assign imem_req_addr_o  = pc_q;
    assign accept = imem_req_valid_o && imem_req_ready_i;

    assign rsp_keep = imem_rsp_valid_i && (drop_q == '0) && !redirect_i;
    assign empty    = (cnt_q == '0);

`ifdef FETCH_BYPASS_EN
    assign byp = empty && rsp_keep;
`else
    assign byp = 1'b0;
`endif

    assign instr_valid_o = (!empty || byp) && !redirect_i;
    assign pop      = instr_valid_o && instr_ready_i;
    assign fifo_pop = pop && !empty;
    assign push     = rsp_keep && !(byp && pop);

    always_comb begin
        instr_o    = NOP;
        instr_pc_o = '0;
        if (!empty) begin
            instr_o    = data_mem[rptr_q];
            instr_pc_o = pc_mem[rptr_q];
        end else if (byp) begin
            instr_o    = imem_rsp_data_i;
            instr_pc_o = rsp_pc_q;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q + CW'(accept) - CW'(imem_rsp_valid_i);
        drop_d   = drop_q;
        cnt_d    = cnt_q + CW'(push) - CW'(fifo_pop);
        wptr_d   = wptr_q + AW'(push);
        rptr_d   = rptr_q + AW'(fifo_pop);
        if (accept) begin
            pc_d = pc_q + 64'd4;
        end
        if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + 64'd4;
        end
        if (imem_rsp_valid_i && drop_q != '0) begin
            drop_d = drop_q - 1'b1;
        end
        // Stale responses still in flight get discarded before new ones land.
        if (redirect_i) begin
            pc_d     = redir_pc;
            rsp_pc_d = redir_pc;
            drop_d   = outst_q - CW'(imem_rsp_valid_i);
            cnt_d    = '0;
            wptr_d   = '0;
            rptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wptr_q] <= imem_rsp_data_i;
            pc_mem[wptr_q]   <= rsp_pc_q;
        end
    end

    a_no_rsp_underflow: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid_i && outst_q == '0));
    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
        inflight <= DEPTH_W);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a queued memory model and delivery scoreboard.
// Build with +define+FETCH_BYPASS_EN to check the zero-latency variant.
module tb_instr_fetch_queue;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [63:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [63:0] instr_pc_o;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic mem_stall = 1'b0;
    logic [63:0] pend [$];
    logic [63:0] mem_dump;
    logic [95:0] got [$];
    logic [95:0] exp_q [$];

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o)
    );

    function automatic logic [31:0] mw(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_5A5A;
    endfunction

    // Memory: accepted addresses queue up, answered in order one per cycle unless stalled.
    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
        end else begin
            if (imem_rsp_valid_i && pend.size() > 0) mem_dump = pend.pop_front();
            if (imem_req_valid_o && imem_req_ready_i) begin
                pend.push_back(imem_req_addr_o);
                acc_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!mem_stall && pend.size() > 0) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mw(pend[0]);
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
        end
    end

    always @(posedge clk) begin
        if (!reset && instr_valid_o && instr_ready_i)
            got.push_back({instr_o, instr_pc_o});
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drain_check(input string tag, input int n, input logic [63:0] pc0);
        logic [95:0] e;
        logic [95:0] o;
        int budget;
        for (int i = 0; i < n; i++)
            exp_q.push_back({mw(pc0 + 64'(4 * i)), pc0 + 64'(4 * i)});
        budget = 0;
        while (got.size() < n && budget < 100) begin
            cyc();
            budget++;
        end
        repeat (4) cyc();
        chk({tag, "_count"}, 96'(got.size()), 96'(n));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 'x;
            if (got.size() > 0) o = got.pop_front();
            chk(tag, o, e);
        end
        got.delete();
    endtask

    initial begin
        int a0;
        repeat (3) cyc();
        chk("rst_req_valid", 96'(imem_req_valid_o), 96'(1'b0));
        chk("rst_instr_valid", 96'(instr_valid_o), 96'(1'b0));
        chk("rst_instr", 96'(instr_o), 96'(NOP));
        chk("rst_instr_pc", 96'(instr_pc_o), 96'(64'd0));
        chk("rst_addr", 96'(imem_req_addr_o), 96'(RPC));

        // Streaming fetch with latency-1 memory
        reset = 1'b0;
        imem_req_ready_i = 1'b1;
        instr_ready_i = 1'b1;
        #1;
        chk("p1_addr0", 96'(imem_req_addr_o), 96'(RPC));
        chk("p1_reqv0", 96'(imem_req_valid_o), 96'(1'b1));
        cyc();
        chk("p1_addr1", 96'(imem_req_addr_o), 96'(RPC + 64'd4));
`ifdef FETCH_BYPASS_EN
        chk("p1_iv1", 96'(instr_valid_o), 96'(1'b1));
        chk("p1_ipc1", 96'(instr_pc_o), 96'(RPC));
`else
        chk("p1_iv1", 96'(instr_valid_o), 96'(1'b0));
`endif
        cyc();
        chk("p1_addr2", 96'(imem_req_addr_o), 96'(RPC + 64'd8));
        chk("p1_iv2", 96'(instr_valid_o), 96'(1'b1));
`ifdef FETCH_BYPASS_EN
        chk("p1_ipc2", 96'(instr_pc_o), 96'(RPC + 64'd4));
`else
        chk("p1_ipc2", 96'(instr_pc_o), 96'(RPC));
`endif
        repeat (4) cyc();
        imem_req_ready_i = 1'b0;
        drain_check("p1_stream", 6, RPC);

        // Credit limit with decode stalled
        instr_ready_i = 1'b0;
        imem_req_ready_i = 1'b1;
        a0 = acc_cnt;
        repeat (8) cyc();
        chk("p2_accepts", 96'(acc_cnt - a0), 96'(4));
        chk("p2_reqv", 96'(imem_req_valid_o), 96'(1'b0));
        chk("p2_iv", 96'(instr_valid_o), 96'(1'b1));
        chk("p2_head", {instr_o, instr_pc_o}, {mw(RPC + 64'd24), RPC + 64'd24});
        instr_ready_i = 1'b1;
        repeat (6) cyc();
        imem_req_ready_i = 1'b0;
        drain_check("p2_drain", 9, RPC + 64'd24);

        // Request held while memory not ready
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("p3_addr_hold", 96'(imem_req_addr_o), 96'(RPC + 64'd60));
            chk("p3_reqv_hold", 96'(imem_req_valid_o), 96'(1'b1));
        end
        imem_req_ready_i = 1'b1;
        repeat (3) cyc();
        imem_req_ready_i = 1'b0;
        drain_check("p3_resume", 3, RPC + 64'd60);

        // Redirect with three requests in flight
        mem_stall = 1'b1;
        imem_req_ready_i = 1'b1;
        repeat (3) cyc();
        imem_req_ready_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 64'h1007;
        #1;
        chk("p4_rd_reqv", 96'(imem_req_valid_o), 96'(1'b0));
        chk("p4_rd_iv", 96'(instr_valid_o), 96'(1'b0));
        cyc();
        redirect_i = 1'b0;
        mem_stall = 1'b0;
        imem_req_ready_i = 1'b1;
        #1;
        chk("p4_addr", 96'(imem_req_addr_o), 96'(64'h1004));
        chk("p4_reqv", 96'(imem_req_valid_o), 96'(1'b1));
        cyc();
        imem_req_ready_i = 1'b0;
        drain_check("p4_deliver", 1, 64'h1004);

        // Redirect coinciding with a response, two in flight
        mem_stall = 1'b1;
        imem_req_ready_i = 1'b1;
        repeat (2) cyc();
        imem_req_ready_i = 1'b0;
        mem_stall = 1'b0;
        cyc();
        redirect_i = 1'b1;
        redirect_pc_i = 64'h2000;
        mem_stall = 1'b1;
        #1;
        chk("p5_rsp_present", 96'(imem_rsp_valid_i), 96'(1'b1));
        chk("p5_rd_iv", 96'(instr_valid_o), 96'(1'b0));
        cyc();
        redirect_i = 1'b0;
        #1;
        chk("p5_addr", 96'(imem_req_addr_o), 96'(64'h2000));
        chk("p5_reqv", 96'(imem_req_valid_o), 96'(1'b1));
        mem_stall = 1'b0;
        imem_req_ready_i = 1'b1;
        cyc();
        imem_req_ready_i = 1'b0;
        drain_check("p5_deliver", 1, 64'h2000);

        // Reset with two in flight and two queued
        instr_ready_i = 1'b0;
        imem_req_ready_i = 1'b1;
        cyc();
        cyc();
        mem_stall = 1'b1;
        cyc();
        cyc();
        #1;
        chk("p6_reqv_full", 96'(imem_req_valid_o), 96'(1'b0));
        chk("p6_head", {instr_o, instr_pc_o}, {mw(64'h2004), 64'h2004});
        reset = 1'b1;
        cyc();
        chk("p6_rst_reqv", 96'(imem_req_valid_o), 96'(1'b0));
        chk("p6_rst_iv", 96'(instr_valid_o), 96'(1'b0));
        chk("p6_rst_instr", 96'(instr_o), 96'(NOP));
        chk("p6_rst_ipc", 96'(instr_pc_o), 96'(64'd0));
        chk("p6_rst_addr", 96'(imem_req_addr_o), 96'(RPC));
        reset = 1'b0;
        mem_stall = 1'b0;
        instr_ready_i = 1'b1;
        #1;
        chk("p6_rel_addr", 96'(imem_req_addr_o), 96'(RPC));
        chk("p6_rel_reqv", 96'(imem_req_valid_o), 96'(1'b1));
        repeat (2) cyc();
        imem_req_ready_i = 1'b0;
        drain_check("p6_restart", 2, RPC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
